// File: rtl/mdu.sv
// Multiply/divide unit for the E stage: owns HI/LO, runs multi-cycle
// MULT/MULTU/DIV/DIVU and requests a stall while a result is pending.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        cancel,
  output logic        busy,
  output logic        md_stall_req,
  output logic [31:0] HI_LO_out,
  output logic        dbg_state
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  localparam logic [3:0] MULT_LAST = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LAST  = 4'(DIV_CYCLES - 1);

  // Handshake: md_stall_req is a level request to the hazard unit; it stays
  // high while an op is in E or running, and the unit accepts a new MD op
  // only on an edge where busy is low and cancel is low.
  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_hi_tmp, w_hi_tmp_nxt;
  logic [31:0] r_lo_tmp, w_lo_tmp_nxt;
  logic [31:0] r_hi, w_hi_nxt;
  logic [31:0] r_lo, w_lo_nxt;

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_div_signed;
  logic [31:0] w_dvd_mag;
  logic [31:0] w_dvs_mag;
  logic [31:0] w_quo_mag;
  logic [31:0] w_rem_mag;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic        w_is_mddiv;

  // Low 64 bits of the product of sign-extended operands is the signed product.
  assign w_prod_s = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
  assign w_prod_u = {32'b0, rs_data} * {32'b0, rt_data};

  // One unsigned divider; signed division works on magnitudes and fixes
  // signs afterwards (0x80000000 / -1 falls out as 0x80000000, rem 0).
  assign w_div_signed = (md_op == OP_DIV);
  assign w_dvd_mag = (w_div_signed && rs_data[31]) ? (32'd0 - rs_data) : rs_data;
  assign w_dvs_mag = (w_div_signed && rt_data[31]) ? (32'd0 - rt_data) : rt_data;
  assign w_quo_mag = (w_dvs_mag == 32'd0) ? 32'd0 : (w_dvd_mag / w_dvs_mag);
  assign w_rem_mag = (w_dvs_mag == 32'd0) ? 32'd0 : (w_dvd_mag % w_dvs_mag);
  assign w_quo = (w_div_signed && (rs_data[31] ^ rt_data[31])) ? (32'd0 - w_quo_mag) : w_quo_mag;
  assign w_rem = (w_div_signed && rs_data[31]) ? (32'd0 - w_rem_mag) : w_rem_mag;

  assign w_is_mddiv = (md_op >= OP_MULT) && (md_op <= OP_DIVU);

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_hi_tmp_nxt = r_hi_tmp;
    w_lo_tmp_nxt = r_lo_tmp;
    w_hi_nxt     = r_hi;
    w_lo_nxt     = r_lo;
    case (r_state)
      S_IDLE: begin
        if (!cancel) begin
          case (md_op)
            OP_MULT: begin
              {w_hi_tmp_nxt, w_lo_tmp_nxt} = w_prod_s;
              w_cnt_nxt   = MULT_LAST;
              w_state_nxt = S_RUN;
            end
            OP_MULTU: begin
              {w_hi_tmp_nxt, w_lo_tmp_nxt} = w_prod_u;
              w_cnt_nxt   = MULT_LAST;
              w_state_nxt = S_RUN;
            end
            OP_DIV, OP_DIVU: begin
              // Divide by zero leaves HI/LO as they are at commit.
              if (rt_data == 32'd0) begin
                w_hi_tmp_nxt = r_hi;
                w_lo_tmp_nxt = r_lo;
              end else begin
                w_hi_tmp_nxt = w_rem;
                w_lo_tmp_nxt = w_quo;
              end
              w_cnt_nxt   = DIV_LAST;
              w_state_nxt = S_RUN;
            end
            OP_MTHI: w_hi_nxt = rs_data;
            OP_MTLO: w_lo_nxt = rs_data;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (r_cnt == 4'd0) begin
          w_hi_nxt    = r_hi_tmp;
          w_lo_nxt    = r_lo_tmp;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_hi_tmp <= 32'd0;
      r_lo_tmp <= 32'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_hi_tmp <= w_hi_tmp_nxt;
      r_lo_tmp <= w_lo_tmp_nxt;
      r_hi     <= w_hi_nxt;
      r_lo     <= w_lo_nxt;
    end
  end

  assign busy         = (r_state == S_RUN);
  assign dbg_state    = r_state;
  assign md_stall_req = busy | (w_is_mddiv & ~cancel);

  always_comb begin
    HI_LO_out = 32'd0;
    if (md_op == OP_MFHI)      HI_LO_out = r_hi;
    else if (md_op == OP_MFLO) HI_LO_out = r_lo;
  end

endmodule
